// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StMemWait,
    StHalt
  } ctrl_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned NUM_REGS         = 32;

endpackage

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// Per-register pending-write scoreboard.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_inc, i_inc_rd         issue of a register-writing instruction to i_inc_rd
//   i_dec, i_dec_rd         commit of a register write to i_dec_rd
//   i_rd_a, i_rd_b          combinational lookup registers
//   o_pend_a, o_pend_b      lookup register has at least one write in flight
module reg_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned SB_W = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic [4:0] i_inc_rd,
  input  logic       i_dec,
  input  logic [4:0] i_dec_rd,
  input  logic [4:0] i_rd_a,
  input  logic [4:0] i_rd_b,
  output logic       o_pend_a,
  output logic       o_pend_b
);

  localparam logic [SB_W-1:0] CntMax = '1;

  logic [SB_W-1:0]     r_cnt [NUM_REGS];
  logic [SB_W-1:0]     w_cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_up, w_dn, w_full, w_empty;
  logic                w_overflow, w_underflow;

  // x0 never receives an increment, so its counter stays at zero forever.
  assign w_up = (i_inc && (i_inc_rd != REG_ZERO)) ? (32'd1 << i_inc_rd) : '0;
  assign w_dn = (i_dec && (i_dec_rd != REG_ZERO)) ? (32'd1 << i_dec_rd) : '0;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_full[i]  = (r_cnt[i] == CntMax);
      w_empty[i] = (r_cnt[i] == '0);
      w_cnt_d[i] = r_cnt[i];
      // Simultaneous inc and dec on one register cancel out.
      if (w_up[i] && !w_dn[i] && !w_full[i]) begin
        w_cnt_d[i] = r_cnt[i] + 1'b1;
      end else if (w_dn[i] && !w_up[i] && !w_empty[i]) begin
        w_cnt_d[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign o_pend_a = (r_cnt[i_rd_a] != '0);
  assign o_pend_b = (r_cnt[i_rd_b] != '0);

  // Counters saturate in hardware; reaching a limit means upstream logic is broken.
  assign w_overflow  = |(w_up & ~w_dn & w_full);
  assign w_underflow = |(w_dn & ~w_up & w_empty);

  sb_no_overflow_a : assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_overflow);
  sb_no_underflow_a : assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_underflow);

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the in-order fetch/decode/exec/writeback pipeline.
// Owns the PC, the pending-write scoreboard and the stage enables. Exec reads
// the register file without forwarding, so decode is held until every source
// register it reads has no write in flight.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_imem_valid                    fetch data valid for o_pc
//   i_id_*                          decoded instruction fields in the decode register
//   i_ex_redirect, i_ex_target      taken branch/jump resolved in exec
//   i_dmem_req, i_dmem_ack          exec memory access and its completion
//   i_wb_*                          writeback commit
//   i_halt_req                      ECALL/EBREAK in exec
//   o_pc                            fetch address
//   o_if_en, o_id_flush             decode register load / clear
//   o_issue, o_ex_bubble            exec register loads instruction / NOP
//   o_wb_en                         writeback register load
//   o_halted, o_misalign_err        core stopped / sticky misaligned target
//   o_stall_cnt                     cycles decode was held
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned SB_W     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_imem_valid,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_rd_we,
  input  logic        i_ex_redirect,
  input  logic [31:0] i_ex_target,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ack,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_rd_we,
  input  logic        i_halt_req,
  output logic [31:0] o_pc,
  output logic        o_if_en,
  output logic        o_id_flush,
  output logic        o_issue,
  output logic        o_ex_bubble,
  output logic        o_wb_en,
  output logic        o_halted,
  output logic        o_misalign_err,
  output logic [31:0] o_stall_cnt
);

  ctrl_state_e r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_stall_cnt;
  logic        r_misalign, w_misalign_d;
  logic        r_drain, w_drain_d;
  logic        w_stall;
  logic        w_pend1, w_pend2, w_hazard;

  reg_scoreboard #(
    .SB_W(SB_W)
  ) u_sb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (o_issue && i_id_rd_we),
    .i_inc_rd (i_id_rd),
    .i_dec    (i_wb_valid && i_wb_rd_we),
    .i_dec_rd (i_wb_rd),
    .i_rd_a   (i_id_rs1),
    .i_rd_b   (i_id_rs2),
    .o_pend_a (w_pend1),
    .o_pend_b (w_pend2)
  );

  // Registered counts only: a commit in this cycle does not release the stall until next cycle.
  assign w_hazard = i_id_valid &&
                    ((i_id_use_rs1 && (i_id_rs1 != REG_ZERO) && w_pend1) ||
                     (i_id_use_rs2 && (i_id_rs2 != REG_ZERO) && w_pend2));

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_misalign_d = r_misalign;
    w_drain_d    = 1'b0;
    w_stall      = 1'b0;
    o_if_en      = 1'b0;
    o_id_flush   = 1'b0;
    o_issue      = 1'b0;
    o_ex_bubble  = 1'b0;
    o_wb_en      = 1'b0;
    o_halted     = 1'b0;
    unique case (r_state)
      StBoot: w_state_d = StRun;
      StRun: begin
        if (i_halt_req) begin
          o_id_flush  = 1'b1;
          o_ex_bubble = 1'b1;
          o_wb_en     = 1'b1;
          w_state_d   = StHalt;
          w_drain_d   = 1'b1;
        end else if (i_ex_redirect) begin
          // Wrong-path decode instruction is dropped; the redirecting instruction still commits.
          o_id_flush  = 1'b1;
          o_ex_bubble = 1'b1;
          o_wb_en     = 1'b1;
          if (i_ex_target[1]) begin
            w_misalign_d = 1'b1;
            w_state_d    = StHalt;
            w_drain_d    = 1'b1;
          end else begin
            w_pc_d = {i_ex_target[31:1], 1'b0};
          end
        end else if (i_dmem_req && !i_dmem_ack) begin
          w_state_d = StMemWait;
          w_stall   = 1'b1;
        end else if (w_hazard) begin
          o_ex_bubble = 1'b1;
          o_wb_en     = 1'b1;
          w_stall     = 1'b1;
        end else begin
          o_issue     = i_id_valid;
          o_ex_bubble = !i_id_valid;
          o_wb_en     = 1'b1;
          o_if_en     = i_imem_valid;
          if (i_imem_valid) begin
            w_pc_d = r_pc + 32'd4;
          end
        end
      end
      StMemWait: begin
        if (i_dmem_ack) begin
          o_wb_en   = 1'b1;
          w_state_d = StRun;
        end else begin
          w_stall = 1'b1;
        end
      end
      StHalt: begin
        o_halted = 1'b1;
        o_wb_en  = r_drain;
      end
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StBoot;
      r_pc        <= RESET_PC;
      r_stall_cnt <= '0;
      r_misalign  <= 1'b0;
      r_drain     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall};
      r_misalign  <= w_misalign_d;
      r_drain     <= w_drain_d;
    end
  end

  assign o_pc           = r_pc;
  assign o_misalign_err = r_misalign;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid, id_valid, id_use_rs1, id_use_rs2, id_rd_we;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_redirect, dmem_req, dmem_ack, wb_valid, wb_rd_we, halt_req;
  logic [31:0] ex_target;
  logic [31:0] pc, stall_cnt;
  logic        if_en, id_flush, issue, ex_bubble, wb_en, halted, misalign_err;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .RESET_PC(32'h0000_0000),
    .SB_W    (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_imem_valid  (imem_valid),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_id_rd       (id_rd),
    .i_id_rd_we    (id_rd_we),
    .i_ex_redirect (ex_redirect),
    .i_ex_target   (ex_target),
    .i_dmem_req    (dmem_req),
    .i_dmem_ack    (dmem_ack),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd),
    .i_wb_rd_we    (wb_rd_we),
    .i_halt_req    (halt_req),
    .o_pc          (pc),
    .o_if_en       (if_en),
    .o_id_flush    (id_flush),
    .o_issue       (issue),
    .o_ex_bubble   (ex_bubble),
    .o_wb_en       (wb_en),
    .o_halted      (halted),
    .o_misalign_err(misalign_err),
    .o_stall_cnt   (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: controller mode, PC, counters, and the list of issued
  // destinations not yet committed (oldest first).
  localparam int MBoot = 0, MRun = 1, MWait = 2, MHalt = 3;
  int          m_mode;
  logic [31:0] m_pc, m_stall;
  bit          m_mis, m_first_halt;
  logic [4:0]  q_rd[$];

  function automatic int pending(input logic [4:0] r);
    int n = 0;
    foreach (q_rd[i]) if (q_rd[i] == r) n++;
    return n;
  endfunction

  task automatic idle_inputs();
    imem_valid = 0; id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd_we = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_rd = 0; ex_redirect = 0; ex_target = 0;
    dmem_req = 0; dmem_ack = 0; wb_valid = 0; wb_rd_we = 0; halt_req = 0;
  endtask

  task automatic model_reset();
    m_mode = MBoot; m_pc = 32'h0; m_stall = 0; m_mis = 0; m_first_halt = 0;
    q_rd.delete();
  endtask

  // Assert reset away from the clock edge, check the reset values, release.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_enables", 32'({if_en, id_flush, issue, ex_bubble, wb_en}), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_misalign", 32'(misalign_err), 32'h0);
    check_eq("rst_stall_cnt", stall_cnt, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: compare DUT against model at the falling edge, advance the model.
  task automatic tick();
    logic e_if, e_fl, e_is, e_bub, e_wb, e_ht;
    logic [31:0] n_pc;
    int   n_mode;
    bit   n_first, n_mis, stall, hz;
    @(negedge clk);
    {e_if, e_fl, e_is, e_bub, e_wb, e_ht} = '0;
    n_pc = m_pc; n_mode = m_mode; n_first = 0; n_mis = m_mis; stall = 0;
    hz = id_valid && ((id_use_rs1 && id_rs1 != 0 && pending(id_rs1) > 0) ||
                      (id_use_rs2 && id_rs2 != 0 && pending(id_rs2) > 0));
    case (m_mode)
      MBoot: n_mode = MRun;
      MRun: begin
        if (halt_req) begin
          e_fl = 1; e_bub = 1; e_wb = 1; n_mode = MHalt; n_first = 1;
        end else if (ex_redirect) begin
          e_fl = 1; e_bub = 1; e_wb = 1;
          if (ex_target[1]) begin
            n_mis = 1; n_mode = MHalt; n_first = 1;
          end else begin
            n_pc = ex_target & ~32'h1;
          end
        end else if (dmem_req && !dmem_ack) begin
          n_mode = MWait; stall = 1;
        end else if (hz) begin
          e_bub = 1; e_wb = 1; stall = 1;
        end else begin
          e_is = id_valid; e_bub = !id_valid; e_wb = 1; e_if = imem_valid;
          if (imem_valid) n_pc = m_pc + 4;
        end
      end
      MWait: begin
        if (dmem_ack) begin
          e_wb = 1; n_mode = MRun;
        end else begin
          stall = 1;
        end
      end
      default: begin
        e_ht = 1; e_wb = m_first_halt;
      end
    endcase
    check_eq("if_en", 32'(if_en), 32'(e_if));
    check_eq("id_flush", 32'(id_flush), 32'(e_fl));
    check_eq("issue", 32'(issue), 32'(e_is));
    check_eq("ex_bubble", 32'(ex_bubble), 32'(e_bub));
    check_eq("wb_en", 32'(wb_en), 32'(e_wb));
    check_eq("halted", 32'(halted), 32'(e_ht));
    check_eq("pc", pc, m_pc);
    check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));
    check_eq("stall_cnt", stall_cnt, m_stall);
    if (wb_valid && wb_rd_we && wb_rd != 0) begin
      for (int i = 0; i < q_rd.size(); i++) begin
        if (q_rd[i] == wb_rd) begin
          q_rd.delete(i);
          break;
        end
      end
    end
    if (e_is && id_rd_we && id_rd != 0) q_rd.push_back(id_rd);
    m_pc = n_pc; m_mode = n_mode; m_first_halt = n_first; m_mis = n_mis;
    m_stall = m_stall + 32'(stall);
    @(posedge clk);
    #1;
  endtask

  task automatic random_inputs();
    imem_valid = ($urandom_range(0, 9) != 0);
    id_valid   = ($urandom_range(0, 4) != 0);
    id_rs1     = 5'($urandom_range(0, 7));
    id_rs2     = 5'($urandom_range(0, 7));
    id_use_rs1 = 1'($urandom_range(0, 1));
    id_use_rs2 = 1'($urandom_range(0, 1));
    id_rd      = 5'($urandom_range(0, 7));
    id_rd_we   = ($urandom_range(0, 1) == 1) && (pending(id_rd) < 3);
    wb_valid   = ($urandom_range(0, 2) == 0);
    if (wb_valid && q_rd.size() > 0 && $urandom_range(0, 5) != 0) begin
      wb_rd = q_rd[0]; wb_rd_we = 1;
    end else begin
      wb_rd = 5'($urandom_range(1, 31)); wb_rd_we = 0;
    end
    dmem_req    = ($urandom_range(0, 4) == 0);
    dmem_ack    = ($urandom_range(0, 2) == 0);
    ex_redirect = 0; halt_req = 0; ex_target = 0;
    if (m_mode != MWait) begin
      ex_redirect = ($urandom_range(0, 11) == 0);
      ex_target   = $urandom;
      if ($urandom_range(0, 7) != 0) ex_target[1] = 1'b0;
      halt_req    = ($urandom_range(0, 149) == 0);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1;

    // Boot then sequential fetch.
    do_reset();
    imem_valid = 1; id_valid = 1;
    repeat (4) tick();
    check_eq("t1_pc", pc, 32'hC);

    // RAW stall on x5 until its commit has been registered.
    do_reset();
    tick();
    imem_valid = 1; id_valid = 1; id_rd = 5; id_rd_we = 1;
    tick();
    id_rd_we = 0; id_use_rs1 = 1; id_rs1 = 5;
    tick();
    wb_valid = 1; wb_rd = 5; wb_rd_we = 1;
    tick();
    wb_valid = 0; wb_rd_we = 0;
    tick();
    check_eq("t2_stall_cnt", stall_cnt, 32'd2);

    // Reads of x0 never stall, even with other registers pending.
    id_rd = 1; id_rd_we = 1; id_use_rs1 = 0;
    tick();
    id_rd = 0; id_rd_we = 0; id_use_rs1 = 1; id_rs1 = 0; id_use_rs2 = 1; id_rs2 = 0;
    tick();
    check_eq("t3_stall_cnt", stall_cnt, 32'd2);

    // Redirect overrides a hazard; the flushed instruction does not touch the scoreboard.
    id_use_rs2 = 0; id_rd = 5; id_rd_we = 1;
    tick();
    id_rs1 = 5; id_rd = 6; ex_redirect = 1; ex_target = 32'h101;
    tick();
    check_eq("t4_pc", pc, 32'h100);
    ex_redirect = 0; id_rd_we = 0; id_rs1 = 6;
    tick();
    id_rs1 = 5;
    tick();

    // Misaligned redirect halts with one drain cycle.
    id_valid = 0; ex_redirect = 1; ex_target = 32'h102;
    tick();
    ex_redirect = 0;
    repeat (3) tick();
    check_eq("t5_halted", 32'(halted), 32'd1);
    check_eq("t5_misalign", 32'(misalign_err), 32'd1);

    // Memory wait, then reset in the middle of a second wait.
    idle_inputs();
    do_reset();
    tick();
    imem_valid = 1; id_valid = 1; id_rd = 7; id_rd_we = 1;
    tick();
    id_rd_we = 0; id_valid = 0; dmem_req = 1;
    repeat (3) tick();
    dmem_ack = 1;
    tick();
    check_eq("t6_stall_cnt", stall_cnt, 32'd3);
    dmem_ack = 0;
    repeat (2) tick();
    do_reset();
    dmem_req = 0; id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
    repeat (2) tick();
    check_eq("t6_sb_cleared", stall_cnt, 32'd0);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      int halt_cycles = 0;
      idle_inputs();
      do_reset();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 299) == 0 || halt_cycles > 4) begin
          halt_cycles = 0;
          do_reset();
        end
        random_inputs();
        tick();
        if (m_mode == MHalt) halt_cycles++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
